// File: rtl/fixed_point_max_dispatch.sv
// fixed_point_max_dispatch: buffers a score vector, tracks its running max,
// then issues it four lanes per group with a one-cycle enable pulse each.
module fixed_point_max_dispatch #(
  parameter int ARITH_TYPE = 1,
  parameter int DATA_WIDTH = 32,
  parameter int INTEGER    = 16,
  parameter int FRACTION   = 16,
  parameter int NUM_INPUTS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  softmax_enable,
  output logic [DATA_WIDTH-1:0] max_input,
  output logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] in3,
  output logic [DATA_WIDTH-1:0] in4,
  output logic [3:0]            lane_valid,
  output logic                  vector_done
);

  localparam int NUM_GROUPS = (NUM_INPUTS + 3) / 4;
  localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  if (NUM_INPUTS < 1 || NUM_INPUTS > 64 ||
      INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_cfg
    $error("fixed_point_max_dispatch: bad parameters");
  end

  typedef enum logic [1:0] {
    S_COLLECT,
    S_EN,
    S_DATA,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [DATA_WIDTH-1:0] lane_q [4];
  logic [DATA_WIDTH-1:0] lane_d [4];
  logic [3:0]            lv_q, lv_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_INPUTS];

  logic accept;
  logic last_el;
  logic last_grp;
  logic gt;

  assign accept   = in_valid & in_ready;
  assign last_el  = (cnt_q == CW'(NUM_INPUTS - 1));
  assign last_grp = (grp_q == GW'(NUM_GROUPS - 1));

  // strict greater: on a tie the earlier word is kept
  always_comb begin
    if (ARITH_TYPE != 0) gt = $signed(in_data) > $signed(max_q);
    else                 gt = in_data > max_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      grp_q   <= '0;
      max_q   <= '0;
      lv_q    <= '0;
      for (int k = 0; k < 4; k++) lane_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      max_q   <= max_d;
      lv_q    <= lv_d;
      lane_q  <= lane_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (accept && cnt_q == CW'(j)) mem_q[j] <= in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (accept && last_el) state_d = S_EN;
      S_EN:      state_d = S_DATA;
      S_DATA:    state_d = last_grp ? S_DONE : S_EN;
      S_DONE:    state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    grp_d  = grp_q;
    max_d  = max_q;
    lane_d = lane_q;
    lv_d   = lv_q;
    if (accept) begin
      cnt_d = last_el ? '0 : cnt_q + 1'b1;
      if (cnt_q == '0 || gt) max_d = in_data;
      if (last_el) grp_d = '0;
    end
    if (state_q == S_DATA && !last_grp) grp_d = grp_q + 1'b1;
    // padding lanes carry the max so max-minus-lane is zero there
    if (state_q == S_EN) begin
      for (int k = 0; k < 4; k++) begin
        lane_d[k] = max_q;
        lv_d[k]   = 1'b0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
          if (int'(grp_q) * 4 + k == j) begin
            lane_d[k] = mem_q[j];
            lv_d[k]   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    in_ready       = 1'b0;
    softmax_enable = 1'b0;
    vector_done    = 1'b0;
    unique case (state_q)
      S_COLLECT: in_ready       = 1'b1;
      S_EN:      softmax_enable = 1'b1;
      S_DONE:    vector_done    = 1'b1;
      default:   ;
    endcase
  end

  assign max_input  = max_q;
  assign in1        = lane_q[0];
  assign in2        = lane_q[1];
  assign in3        = lane_q[2];
  assign in4        = lane_q[3];
  assign lane_valid = lv_q;

endmodule

// File: tb/tb_fixed_point_max_dispatch.sv
// Bench for fixed_point_max_dispatch: three configurations checked every
// cycle against a vector-level model, plus hand-computed literal probes.
module tb_fixed_point_max_dispatch;

  localparam int NC = 3;

  function automatic int cfg_n(input int k);
    return (k == 0) ? 10 : (k == 1) ? 4 : 1;
  endfunction

  function automatic bit cfg_s(input int k);
    return k != 1;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iv   [NC];
  logic [31:0] idat [NC];
  logic        rdy  [NC];
  logic        en   [NC];
  logic        dn   [NC];
  logic [31:0] mx   [NC];
  logic [31:0] ln   [NC][4];
  logic [3:0]  lv   [NC];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NC; k++) begin : g_dut
    fixed_point_max_dispatch #(
      .ARITH_TYPE(cfg_s(k) ? 1 : 0),
      .DATA_WIDTH(32),
      .INTEGER   (16),
      .FRACTION  (16),
      .NUM_INPUTS(cfg_n(k))
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (iv[k]),
      .in_data       (idat[k]),
      .in_ready      (rdy[k]),
      .softmax_enable(en[k]),
      .max_input     (mx[k]),
      .in1           (ln[k][0]),
      .in2           (ln[k][1]),
      .in3           (ln[k][2]),
      .in4           (ln[k][3]),
      .lane_valid    (lv[k]),
      .vector_done   (dn[k])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          k;
    int          s;
    logic [31:0] v;
  } probe_t;
  probe_t probes[$];

  function automatic string sname(input int s);
    case (s)
      0: return "en";
      1: return "done";
      2: return "rdy";
      3: return "max";
      4: return "in1";
      5: return "in2";
      6: return "in3";
      7: return "in4";
      default: return "lv";
    endcase
  endfunction

  function automatic logic [31:0] sel(input int k, input int s);
    case (s)
      0: return {31'b0, en[k]};
      1: return {31'b0, dn[k]};
      2: return {31'b0, rdy[k]};
      3: return mx[k];
      4: return ln[k][0];
      5: return ln[k][1];
      6: return ln[k][2];
      7: return ln[k][3];
      default: return {28'b0, lv[k]};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit gt(input logic [31:0] a, input logic [31:0] b,
                            input bit s);
    return s ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  // model: disp counts cycles since the last element of a vector was taken
  int          disp [NC];
  int          nacc [NC];
  logic [31:0] cur  [NC][64];
  logic [31:0] emax [NC];
  logic [31:0] elan [NC][4];
  logic [3:0]  elv  [NC];

  task automatic model_step(input int k);
    int n, g, gi, idx;
    bit er, ee, ed;
    n = cfg_n(k);
    g = (n + 3) / 4;
    if (!reset) begin
      disp[k] = 0;
      nacc[k] = 0;
      emax[k] = '0;
      elv[k]  = '0;
      for (int j = 0; j < 4; j++) elan[k][j] = '0;
      for (int s = 0; s < 9; s++)
        if (s != 2) chk($sformatf("i%0d_rst_%s", k, sname(s)), sel(k, s), '0);
      return;
    end
    er = disp[k] == 0;
    ee = (disp[k] % 2 == 1) && disp[k] < 2 * g;
    ed = disp[k] == 2 * g + 1;
    if (disp[k] >= 2 && disp[k] % 2 == 0) begin
      gi = (disp[k] - 2) / 2;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * gi + j;
        elan[k][j] = (idx < n) ? cur[k][idx] : emax[k];
        elv[k][j]  = idx < n;
      end
    end
    chk($sformatf("i%0d_en", k), sel(k, 0), {31'b0, ee});
    chk($sformatf("i%0d_done", k), sel(k, 1), {31'b0, ed});
    chk($sformatf("i%0d_rdy", k), sel(k, 2), {31'b0, er});
    chk($sformatf("i%0d_max", k), sel(k, 3), emax[k]);
    for (int j = 0; j < 4; j++)
      chk($sformatf("i%0d_in%0d", k, j + 1), sel(k, 4 + j), elan[k][j]);
    chk($sformatf("i%0d_lv", k), sel(k, 8), {28'b0, elv[k]});
    if (disp[k] != 0) begin
      if (ed) begin
        disp[k] = 0;
        nacc[k] = 0;
      end else begin
        disp[k]++;
      end
    end else if (iv[k] === 1'b1) begin
      cur[k][nacc[k]] = idat[k];
      nacc[k]++;
      emax[k] = cur[k][0];
      for (int i = 1; i < nacc[k]; i++)
        if (gt(cur[k][i], emax[k], cfg_s(k))) emax[k] = cur[k][i];
      if (nacc[k] == n) disp[k] = 1;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) model_step(k);
    foreach (probes[p]) begin
      if (probes[p].c == cyc)
        chk($sformatf("lit_i%0d_%s", probes[p].k, sname(probes[p].s)),
            sel(probes[p].k, probes[p].s), probes[p].v);
    end
  end

  task automatic probe(input int c, input int k, input int s,
                       input logic [31:0] v);
    probe_t p;
    p.c = c;
    p.k = k;
    p.s = s;
    p.v = v;
    probes.push_back(p);
  endtask

  // returns t, the edge at which the last element was accepted
  task automatic send(input int k, input logic [31:0] v[$], input bit gaps,
                      output int t);
    bit acc;
    int w;
    for (int i = 0; i < v.size(); i++) begin
      if (gaps && i > 0) begin
        while ($urandom_range(0, 1) == 1) begin
          iv[k]   = 1'b0;
          idat[k] = $urandom;
          @(posedge clk);
          #1;
        end
      end
      iv[k]   = 1'b1;
      idat[k] = v[i];
      acc = 1'b0;
      w = 0;
      while (!acc) begin
        @(negedge clk);
        acc = rdy[k];
        @(posedge clk);
        #1;
        w++;
        if (w > 200) begin
          $display("FAIL send_timeout inst %0d: in_ready stuck at 0", k);
          $fatal(1);
        end
      end
    end
    iv[k] = 1'b0;
    t = cyc - 1;
  endtask

  task automatic lit_vec_a(input int t);
    probe(t + 1, 0, 0, 1);
    probe(t + 2, 0, 0, 0);
    probe(t + 3, 0, 0, 1);
    probe(t + 5, 0, 0, 1);
    probe(t + 2, 0, 4, 32'h0001_0000);
    probe(t + 2, 0, 5, 32'hFFFE_0000);
    probe(t + 2, 0, 6, 32'h0003_8000);
    probe(t + 2, 0, 7, 32'h0000_4000);
    probe(t + 2, 0, 8, 32'hF);
    probe(t + 6, 0, 8, 32'h3);
    probe(t + 6, 0, 4, 32'hFFFF_0000);
    probe(t + 6, 0, 5, 32'h0001_8000);
    probe(t + 6, 0, 6, 32'h0003_8000);
    probe(t + 6, 0, 7, 32'h0003_8000);
    probe(t + 6, 0, 3, 32'h0003_8000);
    probe(t + 6, 0, 1, 0);
    probe(t + 7, 0, 1, 1);
    probe(t + 7, 0, 2, 0);
    probe(t + 8, 0, 2, 1);
  endtask

  logic [31:0] va[$];
  logic [31:0] vq[$];
  int t;

  initial begin
    for (int k = 0; k < NC; k++) begin
      iv[k]   = 1'b0;
      idat[k] = '0;
    end
    va = {32'h0001_0000, 32'hFFFE_0000, 32'h0003_8000, 32'h0000_4000,
          32'hFFF9_0000, 32'h0003_8000, 32'h0002_0000, 32'h0000_0000,
          32'hFFFF_0000, 32'h0001_8000};

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NC; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        idat[k] = $urandom;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) iv[k] = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < NC; k++) begin
      probe(cyc, k, 2, 1);
      probe(cyc, k, 3, 0);
    end

    // signed vector at full rate, then the same vector with gaps while
    // in_valid is held high through the first dispatch
    send(0, va, 1'b0, t);
    lit_vec_a(t);
    send(0, va, 1'b1, t);
    lit_vec_a(t);

    vq = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
          32'hFFFF_8000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
          32'hFFFF_0000, 32'hFFFF_0000};
    send(0, vq, 1'b0, t);
    probe(t + 7, 0, 3, 32'hFFFF_8000);
    vq = {32'h8000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000,
          32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
          32'hFFFF_0000, 32'hFFFF_0000};
    send(0, vq, 1'b0, t);
    probe(t + 1, 0, 3, 32'h0001_0000);

    vq = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_8000, 32'hFFFF_0000};
    send(1, vq, 1'b0, t);
    probe(t + 3, 1, 3, 32'hFFFF_8000);
    probe(t + 3, 1, 1, 1);
    vq = {32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0005};
    send(1, vq, 1'b0, t);
    probe(t + 1, 1, 0, 1);
    probe(t + 2, 1, 8, 32'hF);
    probe(t + 2, 1, 3, 32'h8000_0000);
    probe(t + 3, 1, 1, 1);

    vq = {32'hFFFE_0000};
    send(2, vq, 1'b0, t);
    probe(t + 1, 2, 0, 1);
    probe(t + 2, 2, 8, 32'h1);
    probe(t + 2, 2, 4, 32'hFFFE_0000);
    probe(t + 2, 2, 5, 32'hFFFE_0000);
    probe(t + 2, 2, 7, 32'hFFFE_0000);
    probe(t + 3, 2, 1, 1);
    vq = {32'h0000_0007};
    send(2, vq, 1'b0, t);
    probe(t + 1, 2, 3, 32'h0000_0007);

    // reset during DATA of group 1
    send(0, va, 1'b0, t);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    probe(t + 5, 0, 0, 0);
    probe(t + 5, 0, 8, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    probe(cyc, 0, 2, 1);
    probe(cyc + 1, 0, 0, 0);
    send(0, va, 1'b0, t);
    lit_vec_a(t);

    repeat (12) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
